// File: rtl/slow_control_bit_shifter_pkg.sv
// slow_control_bit_shifter_pkg: shared sizes and state encoding for the slow-control bit shifter
package slow_control_bit_shifter_pkg;
   localparam int SC_BITS = 592;
   localparam int RS_BITS = 64;
   localparam int FIFO_WIDTH = 16;
   localparam int SC_WORDS_DEF = SC_BITS / FIFO_WIDTH;
   localparam int RS_WORDS_DEF = RS_BITS / FIFO_WIDTH;
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] FETCH = 3'd1;
   localparam logic [2:0] WAIT_DATA = 3'd2;
   localparam logic [2:0] SHIFT_LOW = 3'd3;
   localparam logic [2:0] SHIFT_HIGH = 3'd4;
   localparam logic [2:0] LOAD = 3'd5;
   localparam logic [2:0] DONE = 3'd6;
endpackage

// File: rtl/slow_control_bit_shifter_divider.sv
// slow_clock_divider: half-period tick generator for the serial clock
// Ports: Clk, reset_n (sync, active low), Clear (holds counter at 0, no tick),
//        Tick (high on the last Clk cycle of every CLK_DIV_HALF-cycle half period)
module slow_clock_divider #(
   parameter int CLK_DIV_HALF = 4
) (
   input  logic Clk,
   input  logic reset_n,
   input  logic Clear,
   output logic Tick
);
   logic [7:0] count;
   assign Tick = !Clear && count == 8'(CLK_DIV_HALF - 1);
   always_ff @(posedge Clk)
      if (!reset_n || Clear || Tick) count <= '0;
      else count <= count + 8'd1;
endmodule

// File: rtl/slow_control_bit_shifter.sv
// slow_control_bit_shifter: pops 16-bit FIFO words and shifts them MSB-first into the MICROROC slow-control register
// Ports: Clk, reset_n (sync, active low), SlowControlOrReadScopeSelect (0 SC / 1 read-scope),
//        ShiftStart, ExternalFifoEmpty/ReadEn/Data (FIFO pop side, data one cycle after ReadEn),
//        SrCk/SrIn/SrLoad (chip serial interface), SrOut (chip return), ShiftBusy, ShiftDone, ReadbackError.
// Optional: define SHIFT_READBACK_EN to compare SrOut against the bits shifted one full pass earlier.
module slow_control_bit_shifter
   import slow_control_bit_shifter_pkg::*;
#(
   parameter int CLK_DIV_HALF = 4,
   parameter int SC_WORDS = SC_WORDS_DEF,
   parameter int RS_WORDS = RS_WORDS_DEF,
   parameter int LOAD_CYCLES = 8
) (
   input  logic        Clk,
   input  logic        reset_n,
   input  logic        SlowControlOrReadScopeSelect,
   input  logic        ShiftStart,
   input  logic        ExternalFifoEmpty,
   output logic        ExternalFifoReadEn,
   input  logic [15:0] ExternalFifoData,
   output logic        SrCk,
   output logic        SrIn,
   output logic        SrLoad,
   input  logic        SrOut,
   output logic        ShiftBusy,
   output logic        ShiftDone,
   output logic        ReadbackError
);
   logic [2:0] state;
   logic [15:0] shreg;
   logic [4:0] bitCnt;
   logic [5:0] wordCnt, wordTarget;
   logic [7:0] loadCnt;
   logic tick, shifting, lastBit, lastWord;
   assign shifting = state == SHIFT_LOW || state == SHIFT_HIGH;
   assign lastBit = bitCnt == 5'd15;
   assign lastWord = wordCnt + 6'd1 == wordTarget;
   assign ExternalFifoReadEn = state == FETCH && !ExternalFifoEmpty;
   assign SrCk = state == SHIFT_HIGH;
   assign SrIn = shreg[15];
   assign SrLoad = state == LOAD;
   assign ShiftDone = state == DONE;
   assign ShiftBusy = state != IDLE && state != DONE;

   slow_clock_divider #(.CLK_DIV_HALF(CLK_DIV_HALF)) divider (
      .Clk(Clk),
      .reset_n(reset_n),
      .Clear(!shifting),
      .Tick(tick)
   );

   // The last bit of a word is not shifted out of shreg so SrIn holds through a FETCH stall.
   always_ff @(posedge Clk)
      if (!reset_n) begin
         state <= IDLE;
         shreg <= '0;
         bitCnt <= '0;
         wordCnt <= '0;
         wordTarget <= '0;
         loadCnt <= '0;
      end else begin
         case (state)
            IDLE:
               if (ShiftStart) begin
                  wordTarget <= SlowControlOrReadScopeSelect ? 6'(RS_WORDS) : 6'(SC_WORDS);
                  wordCnt <= '0;
                  bitCnt <= '0;
                  state <= FETCH;
               end
            FETCH: if (!ExternalFifoEmpty) state <= WAIT_DATA;
            WAIT_DATA: begin
               shreg <= ExternalFifoData;
               bitCnt <= '0;
               state <= SHIFT_LOW;
            end
            SHIFT_LOW: if (tick) state <= SHIFT_HIGH;
            SHIFT_HIGH:
               if (tick) begin
                  bitCnt <= bitCnt + 5'd1;
                  if (!lastBit) begin
                     shreg <= {shreg[14:0], 1'b0};
                     state <= SHIFT_LOW;
                  end else begin
                     wordCnt <= wordCnt + 6'd1;
                     loadCnt <= '0;
                     state <= lastWord ? LOAD : FETCH;
                  end
               end
            LOAD: begin
               loadCnt <= loadCnt + 8'd1;
               if (loadCnt == 8'(LOAD_CYCLES - 1)) state <= DONE;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end

`ifdef SHIFT_READBACK_EN
   logic [SC_BITS-1:0] history;
   logic [9:0] passEdges, passLen;
   logic [15:0] readbackLine, lineNext;
   logic readScope, sampleEdge, histBit, unusedLineMsb;
   // A rising SrCk edge happens on the Clk edge that ends SHIFT_LOW.
   assign sampleEdge = state == SHIFT_LOW && tick;
   assign passLen = readScope ? 10'(RS_BITS) : 10'(SC_BITS);
   assign histBit = readScope ? history[RS_BITS-1] : history[SC_BITS-1];
   assign lineNext = {readbackLine[14:0], SrOut};
   assign unusedLineMsb = readbackLine[15];
   always_ff @(posedge Clk)
      if (!reset_n) begin
         history <= '0;
         passEdges <= '0;
         readbackLine <= '0;
         readScope <= 1'b0;
         ReadbackError <= 1'b0;
      end else begin
         if (state == IDLE && ShiftStart) begin
            ReadbackError <= 1'b0;
            readScope <= SlowControlOrReadScopeSelect;
         end
         if (sampleEdge) begin
            history <= {history[SC_BITS-2:0], SrIn};
            readbackLine <= lineNext;
            if (passEdges < 10'(SC_BITS)) passEdges <= passEdges + 10'd1;
            // Only once a full register length has gone in can SrOut echo a known bit.
            if (passEdges >= passLen && lineNext[0] != histBit) ReadbackError <= 1'b1;
         end
      end
`else
   logic unusedSrOut;
   assign unusedSrOut = SrOut;
   assign ReadbackError = 1'b0;
`endif
endmodule

// File: tb/tb_slow_control_bit_shifter.sv
// tb_slow_control_bit_shifter: self-checking bench with FIFO model and bitstream reference
module tb_slow_control_bit_shifter;
   typedef struct {
      string name;
      logic sel;
      logic [63:0] w;
      int expEdges;
      int expLat;
   } vec_t;

   logic Clk = 0, reset_n = 0, sel = 0, ShiftStart = 0, SrOut = 0, stall = 0, randStall = 0, popReq = 0;
   logic ExternalFifoEmpty, ExternalFifoReadEn, SrCk, SrIn, SrLoad, ShiftBusy, ShiftDone, ReadbackError;
   logic [15:0] ExternalFifoData = 0;
   logic [15:0] fifo[$];
   logic captured[$];
   logic allBits[$];
   int level = 0, total = 0, bad = 0;
   int readEns = 0, loadCyc = 0, dones = 0, glitches = 0, badReads = 0, flipAt = -1;
   logic prevCk = 0, prevIn = 0;
   vec_t vecs[4];

   always #5 Clk = ~Clk;
   assign ExternalFifoEmpty = stall || level == 0;

   slow_control_bit_shifter dut (
      .Clk(Clk),
      .reset_n(reset_n),
      .SlowControlOrReadScopeSelect(sel),
      .ShiftStart(ShiftStart),
      .ExternalFifoEmpty(ExternalFifoEmpty),
      .ExternalFifoReadEn(ExternalFifoReadEn),
      .ExternalFifoData(ExternalFifoData),
      .SrCk(SrCk),
      .SrIn(SrIn),
      .SrLoad(SrLoad),
      .SrOut(SrOut),
      .ShiftBusy(ShiftBusy),
      .ShiftDone(ShiftDone),
      .ReadbackError(ReadbackError)
   );

   always @(posedge Clk) popReq <= ExternalFifoReadEn;

   always @(posedge Clk) begin
      #2;
      if (randStall) stall = $urandom_range(0, 7) == 0;
   end

   always @(negedge Clk) begin
      if (ExternalFifoReadEn) begin
         readEns++;
         if (ExternalFifoEmpty) badReads++;
      end
      if (SrLoad) loadCyc++;
      if (ShiftDone) dones++;
      if (SrCk && prevCk && SrIn !== prevIn) glitches++;
      prevCk = SrCk;
      prevIn = SrIn;
      if (popReq && level > 0) begin
         ExternalFifoData = fifo.pop_front();
         level--;
      end
   end

   // Chip model: a shift register of one pass length; SrOut echoes the bit pushed 592 edges ago.
   always @(posedge SrCk) begin
      captured.push_back(SrIn);
      allBits.push_back(SrIn);
      SrOut = (allBits.size() >= 592) ? (allBits[allBits.size() - 592] ^ (allBits.size() == flipAt)) : 1'b0;
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic clearMon();
      captured.delete();
      readEns = 0;
      loadCyc = 0;
      dones = 0;
      glitches = 0;
      badReads = 0;
   endtask

   task automatic pushWords(input logic [15:0] words[$]);
      foreach (words[i]) fifo.push_back(words[i]);
      level += words.size();
   endtask

   task automatic waitDone(input string name, output int lat, input int dupAt);
      lat = 0;
      do begin
         @(negedge Clk);
         lat++;
         ShiftStart = lat == dupAt;
      end while (!ShiftDone && lat < 40000);
      ShiftStart = 0;
      check({name, " done seen"}, ShiftDone, 1);
   endtask

   task automatic checkLoad(input string name, input logic [15:0] words[$], input int expEdges);
      logic expBits[$];
      int mism = 0;
      foreach (words[i]) for (int b = 15; b >= 0; b--) expBits.push_back(words[i][b]);
      repeat (20) @(negedge Clk);
      check({name, " edges"}, captured.size(), expEdges);
      foreach (expBits[i]) if (i >= captured.size() || captured[i] !== expBits[i]) mism++;
      check({name, " stream mismatches"}, mism, 0);
      check({name, " readEn pulses"}, readEns, words.size());
      check({name, " load cycles"}, loadCyc, 8);
      check({name, " done pulses"}, dones, 1);
      check({name, " SrIn moved while SrCk high"}, glitches, 0);
      check({name, " pop while empty"}, badReads, 0);
      check({name, " busy after"}, ShiftBusy, 0);
   endtask

   task automatic runLoad(input string name, input logic s, input logic [15:0] words[$],
                          input int expEdges, input int expLat, input int dupAt);
      int lat;
      clearMon();
      pushWords(words);
      sel = s;
      ShiftStart = 1;
      waitDone(name, lat, dupAt);
      if (expLat > 0) check({name, " latency"}, lat, expLat);
      checkLoad(name, words, expEdges);
   endtask

   function automatic void randWords(input int n, output logic [15:0] words[$]);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
   endfunction

   initial begin
      logic [15:0] words[$];
      logic [15:0] head[$];
      logic [15:0] tail[$];
      int n, hi, re, lat;
      vecs[0] = '{"sc_a5a5", 1'b0, {4{16'hA5A5}}, 592, 4819};
      vecs[1] = '{"rs_corners", 1'b1, {16'h8000, 16'h0001, 16'hFFFF, 16'h0000}, 64, 529};
      vecs[2] = '{"rs_ones", 1'b1, {4{16'hFFFF}}, 64, 529};
      vecs[3] = '{"sc_mixed", 1'b0, {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}, 592, 4819};

      repeat (5) @(negedge Clk);
      check("reset outputs", {ExternalFifoReadEn, SrCk, SrIn, SrLoad, ShiftBusy, ShiftDone, ReadbackError}, 0);
      reset_n = 1;
      @(negedge Clk);

      foreach (vecs[v]) begin
         words.delete();
         n = vecs[v].sel ? 4 : 37;
         for (int k = 0; k < n; k++) words.push_back(vecs[v].w[63 - 16 * (k % 4) -: 16]);
         runLoad(vecs[v].name, vecs[v].sel, words, vecs[v].expEdges, vecs[v].expLat, 0);
      end

      // FIFO starves after word 2: serial clock must park low and no pop may issue.
      randWords(4, words);
      head = words[0:1];
      tail = words[2:3];
      clearMon();
      pushWords(head);
      sel = 1;
      ShiftStart = 1;
      @(negedge Clk);
      ShiftStart = 0;
      n = 0;
      while (readEns < 2 && n < 1000) begin
         @(negedge Clk);
         n++;
      end
      repeat (140) @(negedge Clk);
      re = readEns;
      hi = 0;
      repeat (100) begin
         @(negedge Clk);
         if (SrCk) hi++;
      end
      check("stall SrCk high cycles", hi, 0);
      check("stall readEn count", readEns, re);
      check("stall busy", ShiftBusy, 1);
      pushWords(tail);
      waitDone("stall", lat, 0);
      checkLoad("stall", words, 64);

      // Reset in the middle of word 10 aborts at once.
      randWords(37, words);
      clearMon();
      pushWords(words);
      sel = 0;
      ShiftStart = 1;
      @(negedge Clk);
      ShiftStart = 0;
      n = 0;
      while (readEns < 10 && n < 3000) begin
         @(negedge Clk);
         n++;
      end
      repeat (50) @(negedge Clk);
      reset_n = 0;
      @(negedge Clk);
      check("abort SrCk/SrLoad/Busy/Done", {SrCk, SrLoad, ShiftBusy, ShiftDone}, 0);
      reset_n = 1;
      fifo.delete();
      level = 0;
      repeat (20) @(negedge Clk);
      check("abort done pulses", dones, 0);
      randWords(37, words);
      runLoad("after abort", 1'b0, words, 592, 4819, 0);

      // Second start while busy is ignored.
      randWords(4, words);
      runLoad("dup start rs", 1'b1, words, 64, 529, 200);
      randWords(37, words);
      runLoad("dup start sc", 1'b0, words, 592, 4819, 3000);

      // Random words and selects with random FIFO stalls against the bitstream model.
      randStall = 1;
      for (int r = 0; r < 4; r++) begin
         sel = 1'($urandom_range(0, 1));
         n = sel ? 4 : 37;
         randWords(n, words);
         runLoad($sformatf("random %0d", r), sel, words, n * 16, -1, 0);
      end
      randStall = 0;
      stall = 0;
      @(negedge Clk);

`ifdef SHIFT_READBACK_EN
      reset_n = 0;
      @(negedge Clk);
      reset_n = 1;
      allBits.delete();
      flipAt = -1;
      randWords(37, words);
      runLoad("readback 1", 1'b0, words, 592, 4819, 0);
      check("readback first load", ReadbackError, 0);
      runLoad("readback 2", 1'b0, words, 592, 4819, 0);
      check("readback repeat match", ReadbackError, 0);
      flipAt = allBits.size() + 100;
      runLoad("readback 3", 1'b0, words, 592, 4819, 0);
      check("readback flipped bit", ReadbackError, 1);
      repeat (50) @(negedge Clk);
      check("readback sticky", ReadbackError, 1);
`else
      check("readback tied low", ReadbackError, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
